multdiv_iterative: RTL and testbench

- Iterative signed 32-bit multiply/divide unit, fed directly from the execute stage: operands are the execute-stage ALU operands after bypassing.
- Its result, exception and ready flags are consumed by the multdiv pipeline latch and by writeback.
- Its `running` output is the pipeline's multdiv stall source.
- Multiply uses radix-4 Booth recoding (16 iterations); divide uses non-restoring division (32 iterations).

---
 rtl/multdiv_iterative.sv | 162 ++++++++++++++++
 tb/tb_multdiv_iterative.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_iterative.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (non-restoring) unit.
// running stalls the pipeline; data_result/data_exception are qualified by data_resultRDY.
module multdiv_iterative #(
  parameter int unsigned MULT_ITERS = 16,
  parameter int unsigned DIV_ITERS  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        running
);

  localparam int unsigned W  = 32;
  localparam int unsigned AW = W + 1;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   count;
  logic [AW-1:0]   acc, mcand;
  logic [W-1:0]    q;
  logic            qm1, div_neg, div_zero, div_ovf;

  logic            start_ok, start_mult, start_div, last_mult, last_div;
  logic [W-1:0]    abs_a, abs_b;
  logic [AW+1:0]   acc_ext, m_ext, booth_sum;
  logic [AW-1:0]   mult_acc_n, div_acc_n;
  logic [W-1:0]    mult_q_n, div_q_n;
  logic            mult_qm1_n;
  logic [AW:0]     rem_shift, div_sum;
  logic [W-1:0]    result_n;
  logic            exception_n;

  // Start decode: multiply wins, starts only accepted when not iterating
  always_comb begin
    start_ok   = (state == IDLE) || (state == DONE);
    start_mult = start_ok && ctrl_MULT;
    start_div  = start_ok && !ctrl_MULT && ctrl_DIV;
    last_mult  = (state == MULT) && (count == CW'(MULT_ITERS - 1));
    last_div   = (state == DIV) && (count == CW'(DIV_ITERS - 1));
    abs_a      = data_operandA[W-1] ? W'(0) - data_operandA : data_operandA;
    abs_b      = data_operandB[W-1] ? W'(0) - data_operandB : data_operandB;
  end

  // Radix-4 Booth step; sum is two bits wider so +-2M of the most negative M cannot wrap
  always_comb begin
    acc_ext = {{2{acc[AW-1]}}, acc};
    m_ext   = {{2{mcand[AW-1]}}, mcand};
    case ({q[1:0], qm1})
      3'b001, 3'b010: booth_sum = acc_ext + m_ext;
      3'b011:         booth_sum = acc_ext + (m_ext << 1);
      3'b100:         booth_sum = acc_ext - (m_ext << 1);
      3'b101, 3'b110: booth_sum = acc_ext - m_ext;
      default:        booth_sum = acc_ext;
    endcase
    mult_acc_n = booth_sum[AW+1:2];
    mult_q_n   = {booth_sum[1:0], q[W-1:2]};
    mult_qm1_n = q[1];
  end

  // Non-restoring step on magnitudes; quotient bits are exact, only the remainder would need fixing
  always_comb begin
    rem_shift = {acc, q[W-1]};
    div_sum   = acc[AW-1] ? rem_shift + {2'b00, mcand[W-1:0]}
                          : rem_shift - {2'b00, mcand[W-1:0]};
    div_acc_n = div_sum[AW-1:0];
    div_q_n   = {q[W-2:0], ~div_sum[AW-1]};
  end

  // Final result and exception, produced on the last iteration edge
  always_comb begin
    result_n    = data_result;
    exception_n = data_exception;
    if (last_mult) begin
      result_n    = mult_q_n;
      exception_n = (mult_acc_n[W-1:0] != {W{mult_q_n[W-1]}});
    end else if (last_div) begin
      if (div_zero) begin
        result_n    = '0;
        exception_n = 1'b1;
      end else if (div_ovf) begin
        result_n    = 32'h8000_0000;
        exception_n = 1'b1;
      end else begin
        result_n    = div_neg ? W'(0) - div_q_n : div_q_n;
        exception_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start_mult)     next_state = MULT;
        else if (start_div) next_state = DIV;
        else                next_state = IDLE;
      end
      MULT:    if (last_mult) next_state = DONE;
      DIV:     if (last_div)  next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count          <= '0;
      acc            <= '0;
      mcand          <= '0;
      q              <= '0;
      qm1            <= 1'b0;
      div_neg        <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      running        <= 1'b0;
    end else begin
      count          <= (state == MULT || state == DIV) ? count + CW'(1) : '0;
      data_result    <= result_n;
      data_exception <= exception_n;
      data_resultRDY <= (next_state == DONE);
      running        <= (next_state == MULT) || (next_state == DIV);
      if (start_mult) begin
        acc   <= '0;
        mcand <= {data_operandA[W-1], data_operandA};
        q     <= data_operandB;
        qm1   <= 1'b0;
      end else if (start_div) begin
        acc      <= '0;
        mcand    <= {1'b0, abs_b};
        q        <= abs_a;
        qm1      <= 1'b0;
        div_neg  <= data_operandA[W-1] ^ data_operandB[W-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      end else if (state == MULT) begin
        acc <= mult_acc_n;
        q   <= mult_q_n;
        qm1 <= mult_qm1_n;
      end else if (state == DIV) begin
        acc <= div_acc_n;
        q   <= div_q_n;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iterative.sv
// Directed bench for multdiv_iterative: latency, results, exceptions, hazards, reset abort.
module tb_multdiv_iterative;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, running;

  int n_cmp = 0;
  int n_err = 0;

  multdiv_iterative dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .running        (running)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one op; now=1 drives the start in the current (DONE) cycle. Returns in the RDY cycle.
  task automatic run_op(input string tag, input bit m, input bit d, input bit now,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit exp_exc);
    int n;
    bit busy_ok;
    n = m ? 16 : 32;
    if (!now) @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    busy_ok = 1'b1;
    for (int k = 1; k <= n; k++) begin
      if (running !== 1'b1 || data_resultRDY !== 1'b0) busy_ok = 1'b0;
      @(posedge clock); #1;
    end
    chk({tag, "/busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "/rdy"}, 32'(data_resultRDY), 32'd1);
    chk({tag, "/run_low"}, 32'(running), 32'd0);
    chk({tag, "/res"}, data_result, exp_res);
    chk({tag, "/exc"}, 32'(data_exception), 32'(exp_exc));
  endtask

  initial begin
    int pulses;
    int pulse_cyc;
    logic [31:0] pulse_res;

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #12;
    chk("rst/run", 32'(running), 32'd0);
    chk("rst/rdy", 32'(data_resultRDY), 32'd0);
    chk("rst/res", data_result, 32'd0);
    chk("rst/exc", 32'(data_exception), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("mul_7x6", 1, 0, 0, 32'd7, 32'd6, 32'd42, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("hold/rdy", 32'(data_resultRDY), 32'd0);
    chk("hold/res", data_result, 32'd42);
    run_op("mul_m3x5", 1, 0, 0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 0);
    run_op("mul_ovf", 1, 0, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1);
    run_op("mul_minxmin", 1, 0, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1);
    run_op("mul_minx1", 1, 0, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 0);
    run_op("both_3x4", 1, 1, 0, 32'd3, 32'd4, 32'd12, 0);
    run_op("div_m7d2", 0, 1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("div_by0", 0, 1, 0, 32'd100, 32'd0, 32'd0, 1);
    run_op("div_ovf", 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("div_mind2", 0, 1, 0, 32'h8000_0000, 32'd2, 32'hC000_0000, 0);

    // Back-to-back: each following start is driven in the prior op's RDY cycle
    run_op("b2b_5x5", 1, 0, 0, 32'd5, 32'd5, 32'd25, 0);
    run_op("b2b_m1xm1", 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("b2b_div", 0, 1, 1, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 0);

    // ctrl_DIV pulse at cycle 5 of a multiply must be ignored
    @(negedge clock);
    data_operandA = 32'd123;
    data_operandB = 32'hFFFF_FFFE;
    ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    ctrl_DIV = 1'b1;
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    pulses = 0;
    pulse_cyc = 0;
    pulse_res = '0;
    for (int c = 6; c <= 45; c++) begin
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      if (data_resultRDY === 1'b1) begin
        pulses++;
        pulse_cyc = c;
        pulse_res = data_result;
      end
    end
    chk("haz/pulses", 32'(pulses), 32'd1);
    chk("haz/cycle", 32'(pulse_cyc), 32'd17);
    chk("haz/res", pulse_res, 32'hFFFF_FF0A);

    // Reset in cycle 8 of a divide aborts it without a result pulse
    @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    chk("abort/pre_run", 32'(running), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort/run", 32'(running), 32'd0);
    chk("abort/res", data_result, 32'd0);
    chk("abort/exc", 32'(data_exception), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (data_resultRDY !== 1'b0 || running !== 1'b0) pulses++;
    end
    chk("abort/quiet", 32'(pulses), 32'd0);

    run_op("post_div", 0, 1, 0, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
